mem_port_arb: RTL
=================

MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 SHALL have parameter AW, default 16, meaning address width in bits.
REQ-002 SHALL have parameter STARVE_LIMIT, default 3, meaning the number of consecutive conflict cycles MEM may win before IF is forced through.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  instruction fetch request, held until granted.
REQ-006 if_addr  input  AW  fetch address.
REQ-007 mem_req  input  1  data access request from the MEM stage, held until granted.
REQ-008 mem_we  input  1  1 = store, 0 = load.
REQ-009 mem_addr  input  AW  data address.
REQ-010 mem_wdata  input  16  store data.
REQ-011 ram_en  output  1  single-port RAM enable.
REQ-012 ram_we  output  1  RAM write enable.
REQ-013 ram_addr  output  AW  RAM address.
REQ-014 ram_wdata  output  16  RAM write data.
REQ-015 ram_rdata  input  16  RAM read data, valid 1 cycle after a read enable.
REQ-016 if_rdata  output  16  fetched instruction, held until the next fetch returns.
REQ-017 if_valid  output  1  1-cycle pulse: if_rdata updated this cycle.
REQ-018 mem_rdata  output  16  load data, held until the next load returns.
REQ-019 mem_valid  output  1  1-cycle pulse: load data valid or store committed.
REQ-020 pc_stall  output  1  1 while if_req is high and IF is not granted this cycle.

Function
REQ-021 Grant SHALL be combinational each cycle: only one requester -> that requester; both -> MEM unless the starvation guard fires (REQ-025).
REQ-022 The granted requester SHALL drive ram_en=1 and ram_addr in the same cycle; ram_we=mem_we and ram_wdata=mem_wdata only on a MEM grant; ram_we=0 on an IF grant; ram_en=0 and ram_we=0 when there is no request.
REQ-023 A registered owner tag {none, IF, MEM-load, MEM-store} SHALL capture the grant; in the next cycle, IF -> if_rdata<=ram_rdata with if_valid=1; MEM-load -> mem_rdata<=ram_rdata with mem_valid=1; MEM-store -> mem_valid=1 with mem_rdata unchanged.
REQ-024 Read latency SHALL be exactly 1 cycle from grant to valid pulse; back-to-back grants SHALL sustain 1 access per cycle.
REQ-025 Starvation counter starve_cnt (0..STARVE_LIMIT): increment on each cycle where both request and MEM is granted; clear on any IF grant or when if_req=0; when starve_cnt==STARVE_LIMIT and both request, IF SHALL be granted and MEM SHALL wait.
REQ-026 pc_stall SHALL equal if_req AND NOT IF-granted, combinationally.
REQ-027 A requester that drops its request before grant SHALL cause no access and no valid pulse.

Reset
REQ-028 While reset=0: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0 (grant forced to none), if_valid=0, mem_valid=0, if_rdata=0, mem_rdata=0, owner=none, starve_cnt=0, pc_stall=0.
REQ-029 Reset asserted mid-access SHALL discard the pending response; no valid pulse after release.
REQ-030 After reset releases, the first rising edge SHALL arbitrate normally.

Configuration
REQ-031 Macro MEM_ARB_STARVE_GUARD_EN: when defined, REQ-025 applies; when undefined, starve_cnt is absent and MEM always wins conflicts (strict priority), so IF may stall indefinitely.

Verification
REQ-032 Only if_req=1 with if_addr=0x0010 and RAM[0x0010]=0x4A21 -> ram_en=1 and ram_we=0 that cycle; next cycle if_valid=1 and if_rdata=0x4A21; pc_stall=0 throughout.
REQ-033 if_req and a store (mem_req=1, mem_we=1, mem_addr=0x0200, mem_wdata=0xBEEF) asserted together -> MEM granted, ram_we=1, pc_stall=1 that cycle; next cycle mem_valid=1, IF granted, pc_stall=0.
REQ-034 Guard enabled, STARVE_LIMIT=3, both requests held for 5 cycles -> grants MEM, MEM, MEM, IF, MEM; pc_stall pattern 1,1,1,0,1.
REQ-035 Macro undefined, same stimulus as REQ-034 -> MEM granted all 5 cycles; pc_stall=1 all 5 cycles; no if_valid.
REQ-036 Load granted at cycle t (RAM=0x1234), reset=0 pulsed at t+0.5 -> mem_valid=0 at t+1, mem_rdata=0, all RAM strobes 0.
REQ-037 Alternating IF and load requests, one per cycle -> one valid pulse per cycle routed to the correct output; data matches RAM contents with no loss or duplication.

Source files
------------

// File: rtl/mem_port_arb_if.sv
// Purpose: request/response and RAM-port bundle between the fetch/MEM stages, the arbiter and a single-port RAM.
// Latency: none, wires only.
// Backpressure: requesters hold *_req until granted; pc_stall reports a fetch that lost arbitration.
interface mem_port_arb_if #(
  parameter int AW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_rdata;
  logic [15:0]   if_rdata;
  logic          if_valid;
  logic [15:0]   mem_rdata;
  logic          mem_valid;
  logic          pc_stall;

  // Environment view: the pipeline stages and the RAM.
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata, if_rdata, if_valid,
           mem_rdata, mem_valid, pc_stall
  );

  // Arbiter view.
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata, if_rdata, if_valid,
           mem_rdata, mem_valid, pc_stall
  );
endinterface

// File: rtl/mem_port_arb.sv
// Purpose: arbitrates instruction fetch and MEM-stage accesses onto one single-port RAM (MEM wins conflicts).
// Latency: grant is combinational; the read data and valid pulse arrive 1 cycle after the grant, 1 access per cycle.
// Backpressure: the loser holds its request; pc_stall flags a stalled fetch. MEM_ARB_STARVE_GUARD_EN adds the starvation guard.
module mem_port_arb #(
  parameter int AW           = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clock,
  input  logic          reset,
  mem_port_arb_if.slave bus
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LD, OWN_ST} owner_t;

  owner_t        owner_q, owner_d;
  logic          if_req_g, mem_req_g;
  logic          grant_if, grant_mem;
  logic          force_if;
  logic [AW-1:0] addr_sel;
  logic [15:0]   wdata_sel;
  logic [15:0]   if_rdata_q, mem_rdata_q;

  if (STARVE_LIMIT < 1) begin : g_cfg_check
    $error("STARVE_LIMIT must be at least 1");
  end

  // Requests are masked while reset is low so the grant is forced to none.
  assign if_req_g  = reset & bus.if_req;
  assign mem_req_g = reset & bus.mem_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  assign force_if = (starve_cnt == LIMIT);

  // Count consecutive conflicts lost by IF; any IF grant or idle fetch clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant_if || !bus.if_req) begin
      starve_cnt <= '0;
    end else if (grant_mem) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  // Strict MEM priority: a fetch may stall for as long as MEM keeps requesting.
  assign force_if = 1'b0;
`endif

  // Grant selection, RAM strobes and the owner tag for the response cycle.
  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    owner_d   = OWN_NONE;
    addr_sel  = '0;
    wdata_sel = '0;
    if (if_req_g && (!mem_req_g || force_if)) begin
      grant_if = 1'b1;
      owner_d  = OWN_IF;
      addr_sel = bus.if_addr;
    end else if (mem_req_g) begin
      grant_mem = 1'b1;
      owner_d   = bus.mem_we ? OWN_ST : OWN_LD;
      addr_sel  = bus.mem_addr;
      wdata_sel = bus.mem_wdata;
    end
  end

  assign bus.ram_en    = grant_if | grant_mem;
  assign bus.ram_we    = grant_mem & bus.mem_we;
  assign bus.ram_addr  = addr_sel;
  assign bus.ram_wdata = wdata_sel;
  assign bus.pc_stall  = if_req_g & ~grant_if;

  // Owner tag: remembers who owns the RAM response arriving next cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Hold the last returned fetch and load data between responses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (owner_q == OWN_IF) if_rdata_q  <= bus.ram_rdata;
      if (owner_q == OWN_LD) mem_rdata_q <= bus.ram_rdata;
    end
  end

  // Response cycle passes RAM data straight through; otherwise the held copy is shown.
  assign bus.if_valid  = (owner_q == OWN_IF);
  assign bus.mem_valid = (owner_q == OWN_LD) || (owner_q == OWN_ST);
  assign bus.if_rdata  = (owner_q == OWN_IF) ? bus.ram_rdata : if_rdata_q;
  assign bus.mem_rdata = (owner_q == OWN_LD) ? bus.ram_rdata : mem_rdata_q;

endmodule
